std_mem_d1_arbiter: RTL and testbench

- Round-robin arbiter that lets two requesters (A, B) share one std_mem_d1 instance through the go/done handshake.
- Each requester sees a private memory-like port. The arbiter drives the single memory port and returns read data and a one-cycle done pulse to the requester it served.
- It sits between compiler-generated group logic and the memory primitive, for cases where two parallel arms access the same memory.

---
 rtl/std_mem_d1_arbiter.sv | 121 ++++++++++++
 tb/tb_std_mem_d1_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_arbiter.sv
// std_mem_d1_arbiter: round-robin arbiter sharing one std_mem_d1 between requesters A and B.
// Define MEM_ARB_PERF_EN to add saturating per-requester stall counters.
module std_mem_d1_arbiter #(
   parameter int width    = 32,
   parameter int idx_size = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                a_go,
   input  logic [idx_size-1:0] a_addr0,
   input  logic [width-1:0]    a_write_data,
   input  logic                a_write_en,
   output logic [width-1:0]    a_read_data,
   output logic                a_done,
   input  logic                b_go,
   input  logic [idx_size-1:0] b_addr0,
   input  logic [width-1:0]    b_write_data,
   input  logic                b_write_en,
   output logic [width-1:0]    b_read_data,
   output logic                b_done,
`ifdef MEM_ARB_PERF_EN
   output logic [15:0]         a_stall_cnt,
   output logic [15:0]         b_stall_cnt,
`endif
   output logic [idx_size-1:0] mem_addr0,
   output logic [width-1:0]    mem_write_data,
   output logic                mem_write_en,
   input  logic [width-1:0]    mem_read_data,
   input  logic                mem_done
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, id_q, id_d, we_q, we_d, cool_q, cool_d;
   logic [idx_size-1:0] addr_q, addr_d;
   logic [width-1:0] wdata_q, wdata_d, a_rd_q, a_rd_d, b_rd_q, b_rd_d;
   logic a_elig, b_elig, grant, grant_b;
   // id/last encoding: 0 = A, 1 = B; cool_q masks the just-served requester for one IDLE cycle
   always_comb begin
      a_elig  = a_go && !(cool_q && !last_q);
      b_elig  = b_go && !(cool_q && last_q);
      grant   = a_elig || b_elig;
      grant_b = b_elig && (!a_elig || !last_q);
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      a_rd_d  = a_rd_q;
      b_rd_d  = b_rd_q;
      cool_d  = state_q == RESP;
      case (state_q)
         IDLE: if (grant) begin
            state_d = ACCESS;
            id_d    = grant_b;
            addr_d  = grant_b ? b_addr0 : a_addr0;
            wdata_d = grant_b ? b_write_data : a_write_data;
            we_d    = grant_b ? b_write_en : a_write_en;
         end
         ACCESS: begin
            state_d = we_q ? WAIT : RESP;
            a_rd_d  = (!we_q && !id_q) ? mem_read_data : a_rd_q;
            b_rd_d  = (!we_q && id_q) ? mem_read_data : b_rd_q;
         end
         WAIT: state_d = mem_done ? RESP : WAIT;
         RESP: begin
            state_d = IDLE;
            last_d  = id_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         cool_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         a_rd_q  <= '0;
         b_rd_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         we_q    <= we_d;
         cool_q  <= cool_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         a_rd_q  <= a_rd_d;
         b_rd_q  <= b_rd_d;
      end
   end
   assign mem_addr0      = (state_q == IDLE) ? '0 : addr_q;
   assign mem_write_data = (state_q == IDLE) ? '0 : wdata_q;
   assign mem_write_en   = (state_q == ACCESS) && we_q && !reset;
   assign a_done         = (state_q == RESP) && !id_q && !reset;
   assign b_done         = (state_q == RESP) && id_q && !reset;
   assign a_read_data    = a_rd_q;
   assign b_read_data    = b_rd_q;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] a_stall_q, a_stall_d, b_stall_q, b_stall_d;
   always_comb begin
      a_stall_d = (state_q == IDLE && a_go && !(grant && !grant_b) && a_stall_q != 16'hFFFF) ? a_stall_q + 16'd1 : a_stall_q;
      b_stall_d = (state_q == IDLE && b_go && !(grant && grant_b) && b_stall_q != 16'hFFFF) ? b_stall_q + 16'd1 : b_stall_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         a_stall_q <= '0;
         b_stall_q <= '0;
      end else begin
         a_stall_q <= a_stall_d;
         b_stall_q <= b_stall_d;
      end
   end
   assign a_stall_cnt = a_stall_q;
   assign b_stall_cnt = b_stall_q;
`endif
endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// tb_std_mem_d1_arbiter: directed scoreboard bench for std_mem_d1_arbiter with a behavioural std_mem_d1.
module tb_std_mem_d1_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic a_go = 0, a_write_en = 0, b_go = 0, b_write_en = 0;
   logic [3:0] a_addr0 = 0, b_addr0 = 0, mem_addr0;
   logic [31:0] a_write_data = 0, b_write_data = 0, a_read_data, b_read_data;
   logic [31:0] mem_write_data, mem_read_data;
   logic a_done, b_done, mem_write_en, mem_done = 1'b0;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] a_stall_cnt, b_stall_cnt;
`endif
   logic [31:0] mem [16];
   int cyc = 0, checks = 0, errors = 0, we_cnt = 0;
   logic [3:0] we_addr = 0;
   typedef struct {logic id; logic rd; logic [31:0] data; int cyc;} exp_t;
   exp_t q[$];
   exp_t e;

   std_mem_d1_arbiter #(.width(32), .idx_size(4)) dut (
      .clk(clk), .reset(reset),
      .a_go(a_go), .a_addr0(a_addr0), .a_write_data(a_write_data), .a_write_en(a_write_en),
      .a_read_data(a_read_data), .a_done(a_done),
      .b_go(b_go), .b_addr0(b_addr0), .b_write_data(b_write_data), .b_write_en(b_write_en),
      .b_read_data(b_read_data), .b_done(b_done),
`ifdef MEM_ARB_PERF_EN
      .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt),
`endif
      .mem_addr0(mem_addr0), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
      .mem_read_data(mem_read_data), .mem_done(mem_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural std_mem_d1: combinational read, done one cycle after write_en
   assign mem_read_data = mem[mem_addr0];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr0] <= mem_write_data;
      mem_done <= mem_write_en;
   end

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, got, want);
      end
   endtask

   task automatic at(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic req(input logic id, input logic [3:0] ad, input logic we, input logic [31:0] d);
      if (id) begin
         b_go = 1; b_addr0 = ad; b_write_en = we; b_write_data = d;
      end else begin
         a_go = 1; a_addr0 = ad; a_write_en = we; a_write_data = d;
      end
   endtask

   always @(negedge clk) if (mem_write_en) begin
      we_cnt++;
      we_addr = mem_addr0;
   end

   always @(negedge clk) if (a_done || b_done) begin
      if (a_done && b_done) chk("both_done", 32'd1, 32'd0);
      if (q.size() == 0) chk("unexpected_done", {31'd0, b_done}, {31'd0, !b_done});
      else begin
         e = q.pop_front();
         chk("done_id", {31'd0, b_done}, {31'd0, e.id});
         chk("done_cycle", cyc, e.cyc);
         if (e.rd) chk(e.id ? "b_read_data" : "a_read_data", e.id ? b_read_data : a_read_data, e.data);
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      at(2);
      @(negedge clk);
      chk("rst_a_done", {31'd0, a_done}, 0);
      chk("rst_b_done", {31'd0, b_done}, 0);
      chk("rst_a_rd", a_read_data, 0);
      chk("rst_b_rd", b_read_data, 0);
      chk("rst_mem_we", {31'd0, mem_write_en}, 0);
      chk("rst_mem_addr", {28'd0, mem_addr0}, 0);
      at(3); reset = 0;
      // A write preload, go held into the cooldown cycle
      at(4); req(0, 3, 1, 32'hDEAD_BEEF); q.push_back('{1'b0, 1'b0, 32'h0, 7});
      at(9); a_go = 0;
      at(11); req(0, 3, 0, 32'h0); q.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 13});
      at(14); a_go = 0;
      at(16); req(1, 5, 1, 32'h1234); q.push_back('{1'b1, 1'b0, 32'h0, 19});
      at(20); b_go = 0;
      at(21);
      @(negedge clk);
      chk("we_pulses", we_cnt, 2);
      chk("we_addr", {28'd0, we_addr}, 5);
      chk("mem5", mem[5], 32'h1234);
      at(22); req(0, 5, 0, 32'h0); q.push_back('{1'b0, 1'b1, 32'h1234, 24});
      at(25); a_go = 0;
      at(26); reset = 1;
      at(28); reset = 0;
      @(negedge clk);
      chk("rst2_a_rd", a_read_data, 0);
      // continuous contention out of reset: A first, strict alternation
      at(29);
      req(0, 3, 0, 32'h0);
      req(1, 5, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         q.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 31 + 6 * i});
         q.push_back('{1'b1, 1'b1, 32'h1234, 34 + 6 * i});
      end
      at(53); a_go = 0; b_go = 0;
      // reset in the ACCESS cycle of an A write
      at(56); req(0, 7, 1, 32'hCAFE);
      at(57); reset = 1;
      @(negedge clk);
      chk("rst_access_we", {31'd0, mem_write_en}, 0);
      at(58); reset = 0; a_go = 0;
      @(negedge clk);
      chk("rst_access_a_rd", a_read_data, 0);
      chk("rst_access_idle_addr", {28'd0, mem_addr0}, 0);
      chk("rst_access_mem7", mem[7], 0);
      at(60); req(0, 3, 0, 32'h0); q.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 62});
      at(63); a_go = 0;
      at(65);
      @(negedge clk);
      chk("idle_addr", {28'd0, mem_addr0}, 0);
      chk("idle_wdata", mem_write_data, 0);
      chk("idle_we", {31'd0, mem_write_en}, 0);
      at(70);
      @(negedge clk);
      chk("pending_dones", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
